// File: rtl/ram_pkg.sv
// Shared definitions for the ram_bank slice: access-size codes, controller
// states and the latched request record.
package ram_pkg;

    localparam logic [1:0] HB_BYTE = 2'b00;
    localparam logic [1:0] HB_HALF = 2'b01;
    localparam logic [1:0] HB_WORD = 2'b10;
    localparam logic [1:0] HB_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  hb;
        logic        uload;
    } req_t;

endpackage

// File: rtl/ram_lane_align.sv
// Combinational lane steering for ram_bank: byte enables, size/alignment
// fault, store-data replication and load shift/extension.
module ram_lane_align
    import ram_pkg::*;
(
    input  logic [1:0]  hb,
    input  logic [1:0]  addr_lo,
    input  logic        uload,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic        misalign,
    output logic [31:0] wlanes,
    output logic [31:0] ldata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Reserved size is reported through misalign so the top sees one fault flag.
    always_comb begin
        be       = 4'b0000;
        misalign = 1'b0;
        wlanes   = wdata;
        case (hb)
            HB_BYTE: begin
                be     = 4'b0001 << addr_lo;
                wlanes = {4{wdata[7:0]}};
            end
            HB_HALF: begin
                misalign = addr_lo[0];
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlanes   = {2{wdata[15:0]}};
            end
            HB_WORD: begin
                misalign = (addr_lo != 2'b00);
                be       = 4'b1111;
            end
            default: misalign = 1'b1;
        endcase
        if (misalign) begin
            be = 4'b0000;
        end
    end

    always_comb begin
        ld_byte = rword[{addr_lo, 3'b000} +: 8];
        ld_half = addr_lo[1] ? rword[31:16] : rword[15:0];
        ldata   = rword;
        case (hb)
            HB_BYTE: ldata = uload ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            HB_HALF: ldata = uload ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ldata = rword;
        endcase
    end

endmodule

// File: rtl/ram_bank.sv
// Single-port byte-addressable RAM bank with a req/gnt handshake, optional
// wait states and byte/half/word accesses with fault reporting.
module ram_bank
    import ram_pkg::*;
#(
    parameter int    DEPTH_WORDS = 256,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ce_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  hb_i,
    input  logic        uload_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        err_o
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    state_e        state;
    logic [3:0]    wait_cnt;
    req_t          req_q;
    req_t          cur;
    logic          accept;
    logic          go_resp;
    logic          fault;
    logic          misalign;
    logic          out_of_range;
    logic          mem_we;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   ldata;
    logic [31:0]   rword;
    logic [29:0]   word_addr;
    logic [AW-1:0] idx;
    logic [31:0]   rdata_q;
    logic          rvalid_q;
    logic          err_q;

    logic [7:0]    lane_mem [4][DEPTH_WORDS];

    assign accept = (state == ST_IDLE) && req_i && ce_i;

    // With no wait states the access completes on the accepting edge, before
    // the request is latched, so the live inputs feed the datapath in IDLE.
    always_comb begin
        if (state == ST_IDLE) begin
            cur.we    = we_i;
            cur.addr  = addr_i;
            cur.wdata = wdata_i;
            cur.hb    = hb_i;
            cur.uload = uload_i;
        end else begin
            cur = req_q;
        end
    end

    assign word_addr    = cur.addr[31:2];
    assign out_of_range = (word_addr >> AW) != 30'd0;
    assign idx          = cur.addr[2 +: AW];
    assign fault        = misalign || out_of_range;

    always_comb begin
        go_resp = 1'b0;
        if (rst_ni) begin
            case (state)
                ST_IDLE: go_resp = accept && (WAIT_STATES == 0);
                ST_WAIT: go_resp = (wait_cnt == 4'd0);
                default: go_resp = 1'b0;
            endcase
        end
    end

    assign mem_we = go_resp && cur.we && !fault;

    ram_lane_align u_align (
        .hb       (cur.hb),
        .addr_lo  (cur.addr[1:0]),
        .uload    (cur.uload),
        .wdata    (cur.wdata),
        .rword    (rword),
        .be       (be),
        .misalign (misalign),
        .wlanes   (wlanes),
        .ldata    (ldata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request fields are only consumed outside IDLE, after being captured here.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            req_q <= cur;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int l = 0; l < 4; l++) begin
            if (mem_we && be[l]) begin
                lane_mem[l][idx] <= wlanes[8*l +: 8];
            end
        end
    end

    assign rword = {lane_mem[3][idx], lane_mem[2][idx], lane_mem[1][idx], lane_mem[0][idx]};

    // Response registers hold values only for the single RESP cycle.
    always_ff @(posedge clk_i) begin
        if (!go_resp) begin
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q    <= fault;
            rvalid_q <= !fault && !cur.we;
            rdata_q  <= (!fault && !cur.we) ? ldata : 32'h0;
        end
    end

    assign gnt_o    = (state == ST_RESP);
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;

endmodule
